// File: rtl/eth_filter_pkg.sv
// Shared definitions for the receive-side destination-MAC filter.
package eth_filter_pkg;

  // Frame-level FSM states.
  typedef enum logic [1:0] {
    StHdr    = 2'd0,
    StReplay = 2'd1,
    StPass   = 2'd2,
    StDrop   = 2'd3
  } state_e;

  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
  localparam int unsigned HDR_LEN   = 6;

  // Index of the final destination-address byte within the header buffer.
  localparam logic [2:0] HDR_LAST_IDX = 3'(HDR_LEN - 1);

endpackage

// File: rtl/axis_skid_reg.sv
// One-entry registered AXI-Stream stage. Upstream ready is combinational from
// the downstream side so a continuously ready sink sees no bubbles.
module axis_skid_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [Width-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [Width-1:0] data_q;
  logic             valid_q;

  // The slot can take a new beat when empty or when it is being drained.
  assign s_ready = m_ready | ~valid_q;
  assign m_data  = data_q;
  assign m_valid = valid_q;

  // Load the slot on every cycle it is free; data only moves with a valid beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (s_ready) begin
      valid_q <= s_valid;
      if (s_valid) begin
        data_q <= s_data;
      end
    end
  end

endmodule

// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC filter on the 8-bit receive stream. Buffers the 6-byte
// destination, decides accept/drop, then replays the header and forwards the
// rest of the frame, or swallows it.
module eth_rx_mac_filter
  import eth_filter_pkg::*;
#(
  parameter bit ENABLE_MCAST = 1'b1,
  parameter bit OUTPUT_REG   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic [47:0] local_mac,
  input  logic        promisc_enable,
  input  logic        bcast_enable,
  input  logic        mcast_enable,
  output logic        frame_accepted,
  output logic        frame_dropped,
  output logic        frame_runt
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [7:0]  hdr_buf_q [HDR_LEN];
  logic        last_pending_q;
  logic        tuser_lat_q;
  logic        accepted_q, dropped_q, runt_q;

  // Stream feeding the output stage (register or direct).
  logic [7:0]  int_tdata;
  logic        int_tvalid, int_tready, int_tlast, int_tuser;
  logic        s_ready_raw, int_valid_raw;

  logic        s_hs, int_hs;
  logic [47:0] dest;
  logic        is_match;

  assign s_axis_tready = rst_n & s_ready_raw;
  assign int_tvalid    = rst_n & int_valid_raw;
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign int_hs        = int_tvalid & int_tready;

  // The sixth byte is still on the bus in the decision cycle.
  assign dest = {hdr_buf_q[0], hdr_buf_q[1], hdr_buf_q[2], hdr_buf_q[3], hdr_buf_q[4],
                 s_axis_tdata};
  assign is_match = promisc_enable
                  | (dest == local_mac)
                  | (bcast_enable & (dest == MAC_BCAST))
                  | (ENABLE_MCAST & mcast_enable & dest[40]);

  assign frame_accepted = accepted_q;
  assign frame_dropped  = dropped_q;
  assign frame_runt     = runt_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StHdr;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdr: begin
        if (s_hs && (cnt_q == HDR_LAST_IDX)) begin
          if (is_match) begin
            state_d = StReplay;
          end else if (!s_axis_tlast) begin
            state_d = StDrop;
          end
        end
      end
      StReplay: begin
        if (int_hs && (cnt_q == HDR_LAST_IDX)) begin
          state_d = last_pending_q ? StHdr : StPass;
        end
      end
      StPass, StDrop: begin
        if (s_hs && s_axis_tlast) begin
          state_d = StHdr;
        end
      end
      default: state_d = StHdr;
    endcase
  end

  // FSM outputs: input ready and the internal output stream.
  always_comb begin
    s_ready_raw   = 1'b0;
    int_valid_raw = 1'b0;
    int_tdata     = s_axis_tdata;
    int_tlast     = s_axis_tlast;
    int_tuser     = s_axis_tuser;
    unique case (state_q)
      StHdr: begin
        s_ready_raw = 1'b1;
      end
      StReplay: begin
        int_valid_raw = 1'b1;
        int_tdata     = hdr_buf_q[cnt_q];
        int_tlast     = (cnt_q == HDR_LAST_IDX) & last_pending_q;
        int_tuser     = (cnt_q == HDR_LAST_IDX) & last_pending_q & tuser_lat_q;
      end
      StPass: begin
        int_valid_raw = s_axis_tvalid;
        s_ready_raw   = int_tready;
      end
      StDrop: begin
        s_ready_raw = 1'b1;
      end
      default: s_ready_raw = 1'b0;
    endcase
  end

  // Header capture, replay index, end-of-frame latch and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= 3'd0;
      last_pending_q <= 1'b0;
      tuser_lat_q    <= 1'b0;
      accepted_q     <= 1'b0;
      dropped_q      <= 1'b0;
      runt_q         <= 1'b0;
    end else begin
      accepted_q <= 1'b0;
      dropped_q  <= 1'b0;
      runt_q     <= 1'b0;
      unique case (state_q)
        StHdr: begin
          if (s_hs) begin
            hdr_buf_q[cnt_q] <= s_axis_tdata;
            if (cnt_q == HDR_LAST_IDX) begin
              cnt_q          <= 3'd0;
              last_pending_q <= s_axis_tlast;
              tuser_lat_q    <= s_axis_tuser;
              accepted_q     <= is_match;
              dropped_q      <= ~is_match;
            end else if (s_axis_tlast) begin
              cnt_q     <= 3'd0;
              runt_q    <= 1'b1;
              dropped_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        StReplay: begin
          if (int_hs) begin
            cnt_q <= (cnt_q == HDR_LAST_IDX) ? 3'd0 : cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  if (OUTPUT_REG) begin : g_out_reg
    logic [9:0] out_bus;

    axis_skid_reg #(
      .Width(10)
    ) u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  ({int_tlast, int_tuser, int_tdata}),
      .s_valid (int_tvalid),
      .s_ready (int_tready),
      .m_data  (out_bus),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready)
    );

    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = out_bus;
  end else begin : g_out_direct
    assign m_axis_tdata  = int_tdata;
    assign m_axis_tvalid = int_tvalid;
    assign m_axis_tlast  = int_tlast;
    assign m_axis_tuser  = int_tuser;
    assign int_tready    = m_axis_tready;
  end

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Self-checking bench for eth_rx_mac_filter: frame-level model plus directed frames.
module tb_eth_rx_mac_filter;

  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MISS  = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid, s_ready, s_last, s_user;
  logic [7:0]  m_data;
  logic        m_valid, m_ready, m_last, m_user;
  logic [47:0] local_mac;
  logic        promisc, bcast, mcast;
  logic        frame_accepted, frame_dropped, frame_runt;

  eth_rx_mac_filter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_data),
    .s_axis_tvalid  (s_valid),
    .s_axis_tready  (s_ready),
    .s_axis_tlast   (s_last),
    .s_axis_tuser   (s_user),
    .m_axis_tdata   (m_data),
    .m_axis_tvalid  (m_valid),
    .m_axis_tready  (m_ready),
    .m_axis_tlast   (m_last),
    .m_axis_tuser   (m_user),
    .local_mac      (local_mac),
    .promisc_enable (promisc),
    .bcast_enable   (bcast),
    .mcast_enable   (mcast),
    .frame_accepted (frame_accepted),
    .frame_dropped  (frame_dropped),
    .frame_runt     (frame_runt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model state: expected output beats {last, user, data} and pulse counts.
  logic [9:0] exp_q [$];
  int exp_acc = 0, exp_drop = 0, exp_runt = 0;
  int obs_acc = 0, obs_drop = 0, obs_runt = 0;
  int out_bytes = 0;
  int stall_cnt = 0;
  bit rand_mode = 1'b0;
  bit measure_lat = 1'b0;
  bit lat_arm = 1'b0;
  int hs6_cyc = 0;
  int lat_meas = -1;
  bit hold_chk = 1'b0;
  logic [9:0] held_bus = '0;
  logic [9:0] last_bus = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit model_match(input logic [47:0] d);
    return promisc || (d == local_mac) || (bcast && (d == BCAST)) || (mcast && d[40]);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: scoreboard compare, hold-stability, pulse counting.
  initial forever begin
    logic [9:0] bus;
    logic [9:0] exp_bus;
    @(negedge clk);
    bus = {m_last, m_user, m_data};
    if (rst_n) begin
      if (hold_chk) check("hold_stable", 64'({m_valid, bus}), 64'({1'b1, held_bus}));
      hold_chk = m_valid && !m_ready;
      held_bus = bus;
      if (m_valid && m_ready) begin
        out_bytes++;
        last_bus = bus;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, expected no beat", bus);
        end else begin
          exp_bus = exp_q.pop_front();
          check("out_beat", 64'(bus), 64'(exp_bus));
        end
      end
      if (frame_accepted) obs_acc++;
      if (frame_dropped) obs_drop++;
      if (frame_runt) begin
        obs_runt++;
        check("runt_with_drop", 64'(frame_dropped), 64'(1));
      end
      if (lat_arm && m_valid) begin
        lat_meas = cyc - hs6_cyc;
        lat_arm = 1'b0;
      end
    end else begin
      hold_chk = 1'b0;
    end
  end

  task automatic send_frame(input logic [47:0] dest, input int len, input bit user,
                            input bit last_en);
    logic [7:0] fb [$];
    for (int i = 0; i < len; i++) begin
      fb.push_back(i < 6 ? dest[47 - 8 * i -: 8] : 8'(i * 7 + len));
    end
    if (len < 6) begin
      exp_runt++;
      exp_drop++;
    end else if (model_match(dest)) begin
      exp_acc++;
      for (int i = 0; i < len; i++) begin
        exp_q.push_back({last_en && (i == len - 1), user && last_en && (i == len - 1), fb[i]});
      end
    end else begin
      exp_drop++;
    end
    stall_cnt = 0;
    for (int i = 0; i < len; i++) begin
      bit ok;
      int guard;
      s_valid = 1'b1;
      s_data  = fb[i];
      s_last  = last_en && (i == len - 1);
      s_user  = user && s_last;
      ok = 1'b0;
      guard = 0;
      while (!ok) begin
        @(negedge clk);
        ok = s_ready;
        if (!ok) stall_cnt++;
        if (ok && (i == 5) && measure_lat) begin
          hs6_cyc = cyc;
          lat_arm = 1'b1;
        end
        @(posedge clk);
        #1;
        guard++;
        if (guard > 1000) begin
          $display("FAIL input_stall: byte %0d not accepted, expected acceptance", i);
          $fatal(1, "input stalled");
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_user  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || m_valid) && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 3000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("acc_count", 64'(obs_acc), 64'(exp_acc));
    check("drop_count", 64'(obs_drop), 64'(exp_drop));
    check("runt_count", 64'(obs_runt), 64'(exp_runt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int o0, a0, d0, r0;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    s_last = 1'b0;
    s_user = 1'b0;
    m_ready = 1'b1;
    local_mac = LOCAL;
    promisc = 1'b0;
    bcast = 1'b1;
    mcast = 1'b1;

    // Reset state.
    @(negedge clk);
    check("reset_tready", 64'(s_ready), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", 64'({m_valid, m_last, m_user}), 64'(0));
    check("reset_pulses", 64'({frame_accepted, frame_dropped, frame_runt}), 64'(0));
    check("idle_tready", 64'(s_ready), 64'(1));
    @(posedge clk);
    #1;

    // 1: matching 64-byte frame.
    o0 = out_bytes; a0 = obs_acc;
    measure_lat = 1'b1;
    send_frame(LOCAL, 64, 1'b0, 1'b1);
    measure_lat = 1'b0;
    check("t1_replay_stall", 64'(stall_cnt), 64'(6));
    drain();
    check("t1_out_bytes", 64'(out_bytes - o0), 64'(64));
    check("t1_accept_pulses", 64'(obs_acc - a0), 64'(1));
    check("t1_latency", 64'(lat_meas), 64'(2));
    check("t1_last_beat", 64'(last_bus), 64'({1'b1, 1'b0, 8'(63 * 7 + 64)}));

    // 2: miss.
    o0 = out_bytes; d0 = obs_drop;
    send_frame(MISS, 64, 1'b0, 1'b1);
    check("t2_no_stall", 64'(stall_cnt), 64'(0));
    drain();
    check("t2_out_bytes", 64'(out_bytes - o0), 64'(0));
    check("t2_drop_pulses", 64'(obs_drop - d0), 64'(1));

    // 3: broadcast and multicast, each enable on and off.
    mcast = 1'b0;
    o0 = out_bytes;
    send_frame(BCAST, 20, 1'b0, 1'b1);
    drain();
    check("t3_bcast_on", 64'(out_bytes - o0), 64'(20));
    bcast = 1'b0;
    o0 = out_bytes;
    send_frame(BCAST, 20, 1'b0, 1'b1);
    drain();
    check("t3_bcast_off", 64'(out_bytes - o0), 64'(0));
    bcast = 1'b1;
    mcast = 1'b1;
    o0 = out_bytes;
    send_frame(MCAST, 20, 1'b0, 1'b1);
    drain();
    check("t3_mcast_on", 64'(out_bytes - o0), 64'(20));
    mcast = 1'b0;
    o0 = out_bytes;
    send_frame(MCAST, 20, 1'b0, 1'b1);
    drain();
    check("t3_mcast_off", 64'(out_bytes - o0), 64'(0));
    mcast = 1'b1;

    // 4: runt, then a full frame.
    o0 = out_bytes; r0 = obs_runt; d0 = obs_drop;
    send_frame(LOCAL, 4, 1'b0, 1'b1);
    drain();
    check("t4_runt_pulse", 64'(obs_runt - r0), 64'(1));
    check("t4_runt_drop", 64'(obs_drop - d0), 64'(1));
    check("t4_runt_out", 64'(out_bytes - o0), 64'(0));
    send_frame(LOCAL, 64, 1'b0, 1'b1);
    drain();
    check("t4_after_runt", 64'(out_bytes - o0), 64'(64));

    // 5: exact 6-byte frame with tuser on the last byte.
    o0 = out_bytes;
    send_frame(LOCAL, 6, 1'b1, 1'b1);
    drain();
    check("t5_out_bytes", 64'(out_bytes - o0), 64'(6));
    check("t5_last_beat", 64'(last_bus), 64'({1'b1, 1'b1, 8'h01}));
    o0 = out_bytes;
    send_frame(LOCAL, 10, 1'b0, 1'b1);
    drain();
    check("t5_next_frame", 64'(out_bytes - o0), 64'(10));

    // 6a: random backpressure.
    rand_mode = 1'b1;
    o0 = out_bytes;
    send_frame(LOCAL, 64, 1'b0, 1'b1);
    send_frame(MISS, 15, 1'b0, 1'b1);
    send_frame(BCAST, 37, 1'b1, 1'b1);
    send_frame(LOCAL, 100, 1'b0, 1'b1);
    drain();
    check("t6_out_bytes", 64'(out_bytes - o0), 64'(201));
    rand_mode = 1'b0;
    @(posedge clk);
    #1;

    // 6b: reset in the middle of PASS.
    send_frame(LOCAL, 20, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t6_reset_mvalid", 64'(m_valid), 64'(0));
    @(posedge clk);
    #1;
    o0 = out_bytes; d0 = obs_drop;
    send_frame(MISS, 30, 1'b0, 1'b1);
    drain();
    check("t6_fresh_drop", 64'(obs_drop - d0), 64'(1));
    check("t6_fresh_no_out", 64'(out_bytes - o0), 64'(0));
    send_frame(LOCAL, 30, 1'b0, 1'b1);
    drain();
    check("t6_fresh_accept", 64'(out_bytes - o0), 64'(30));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_rx_mac_filter.md
Name: eth_rx_mac_filter

Overview:
- Streaming destination-MAC filter on the 8-bit receive AXI-Stream leaving the 1G MAC/FIFO receive path (rx_axis).
- Captures the first 6 bytes of each frame, then decides. Accepted frames are replayed and streamed downstream unchanged. Rejected or runt frames are consumed and discarded.
- Sits between the MAC FIFO output and the Ethernet header parser, in the logic clock domain.

Parameters:
- ENABLE_MCAST, default 1: accept group-address frames (dest bit 0 of first byte = 1) when mcast_enable is high. 0 forces rejection.
- OUTPUT_REG, default 1: 1 means a registered output stage with a skid slot; 0 means m_axis is driven directly from the state logic.

Ports:
- clk  in  1  logic clock
- rst_n  in  1  reset, synchronous, active-low
- s_axis_tdata  in  8  input frame byte
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last byte of frame
- s_axis_tuser  in  1  bad-frame flag, sampled with tlast
- m_axis_tdata  out  8  output byte
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output last
- m_axis_tuser  out  1  output bad-frame flag
- local_mac  in  48  station address; byte 0 on the wire = local_mac[47:40]
- promisc_enable  in  1  accept all frames of 6 bytes or more
- bcast_enable  in  1  accept FF:FF:FF:FF:FF:FF
- mcast_enable  in  1  accept group addresses (gated by ENABLE_MCAST)
- frame_accepted  out  1  one-cycle pulse per accepted frame
- frame_dropped  out  1  one-cycle pulse per rejected frame
- frame_runt  out  1  one-cycle pulse per frame ending before byte 6; frame_dropped pulses in the same cycle

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to HDR and the byte counter to 0.
  - m_axis_tvalid, m_axis_tlast, m_axis_tuser and all status pulses go to 0.
  - s_axis_tready goes to 0 for the reset cycle.
  - Any frame in progress is abandoned. Input bytes after reset are treated as a new frame start.
- Configuration inputs are sampled once per frame, in the cycle the 6th byte is accepted.
- HDR state:
  - s_axis_tready = 1.
  - Each accepted byte is written to hdr_buf[cnt] and cnt increments (3 bits, range 0..5).
  - tlast with cnt < 5: pulse frame_runt and frame_dropped, reset cnt to 0, stay in HDR. Nothing is emitted.
- Decision on the cycle byte 6 is accepted (cnt == 5):
  - match = promisc_enable OR (dest == local_mac) OR (bcast_enable AND dest == all-ones) OR (ENABLE_MCAST AND mcast_enable AND dest[40] == 1).
  - Note dest[40] is the group bit of wire byte 0.
  - If match: pulse frame_accepted and go to REPLAY.
  - If not: pulse frame_dropped. Go to HDR if byte 6 carried tlast, otherwise to DROP.
  - If byte 6 carried tlast, latch last_pending = 1 and latch tuser.
- REPLAY state:
  - s_axis_tready = 0.
  - Emits hdr_buf[0..5] in order, one per m_axis handshake.
  - On byte 5: tlast and tuser come from the latched values if last_pending; otherwise tlast = 0.
  - After byte 5: go to HDR if last_pending, otherwise to PASS.
- PASS state:
  - Bytes pass through with tlast and tuser intact.
  - s_axis_tready = m_axis_tready OR NOT m_axis_tvalid when OUTPUT_REG = 1; otherwise s_axis_tready = m_axis_tready.
  - Input tlast handshake: go to HDR.
- DROP state:
  - s_axis_tready = 1 and bytes are discarded.
  - Input tlast handshake: go to HDR.
- Handshake rules:
  - Once m_axis_tvalid is asserted, it and all m_axis data fields stay stable until m_axis_tready.
  - No bubbles in PASS when both sides are continuously ready.
- Latency with OUTPUT_REG = 1:
  - First output byte appears 2 cycles after the 6th input byte is accepted.
  - Each frame adds 6 bytes of input stall for the replay.
- Back-to-back frames: the first byte of the next frame is accepted in HDR in the cycle after the previous tlast handshake completes.

Decomposition:
- Shared package eth_filter_pkg:
  - state encoding (HDR, REPLAY, PASS, DROP)
  - MAC_BCAST constant (48'hFFFFFFFFFFFF)
  - HDR_LEN = 6
- Sub-module axis_skid_reg: the one-entry output register stage, instantiated when OUTPUT_REG = 1.

Test Plan:
1. Match: local_mac=02:00:00:00:00:01, 64-byte frame to that destination with m_axis_tready=1 → identical 64 bytes out, tlast on byte 64, one frame_accepted pulse.
2. Miss: same setup, frame to 02:00:00:00:00:02 with promisc=0, bcast=1, mcast=1 → no m_axis_tvalid, one frame_dropped pulse, s_axis_tready held high for all 64 bytes.
3. Broadcast and multicast:
   - FF×6 destination with bcast=1 → accepted; with bcast=0 → dropped.
   - 01:00:5E:00:00:01 destination with mcast=1 → accepted; with mcast=0 → dropped.
4. Runt: 4-byte frame with tlast on byte 4 → frame_runt and frame_dropped pulse together, no output; the next 64-byte matching frame passes intact.
5. Exact 6-byte frame, matching, tuser=1 on byte 6 → 6 output bytes, tlast=1 and tuser=1 on byte 6, state returns to HDR.
6. Backpressure and reset:
   - m_axis_tready toggled randomly at 50% → output data identical to input.
   - rst_n pulsed low mid-PASS → m_axis_tvalid=0 next cycle, and the following frame is filtered from a fresh header.
